usart_tx_buf: RTL and testbench



---
 rtl/usart_pkg.sv | 22 ++
 rtl/usart_fifo.sv | 64 ++++++
 rtl/usart_tx_buf.sv | 171 +++++++++++++++++
 tb/tb_usart_tx_buf.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// Shared types and frame constants for the buffered UART transmitter.
// Optional even parity is enabled by defining USART_PARITY_EN.
package usart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Cycles per bit; integer division truncates toward zero.
    function automatic int baud_div(input int clk_fre, input int bps);
        return clk_fre / bps;
    endfunction

endpackage

// File: rtl/usart_fifo.sv
// Synchronous FIFO with registered count; full/empty derive from the count.
// Pointers are log2(DEPTH) bits and wrap naturally (DEPTH is a power of 2).
module usart_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             push_d;
    logic             pop_d;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[rptr_q];

    // Requests are qualified so overflow and underflow are impossible.
    assign push_d = push && !full;
    assign pop_d  = pop && !empty;

    // Pointer and occupancy tracking; push and pop together keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_d) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_d) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push_d && !pop_d) begin
                count_q <= count_q + CW'(1);
            end else if (pop_d && !push_d) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_d) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/usart_tx_buf.sv
// Buffered UART transmitter: valid/ready byte intake, FIFO, 8N1 serialiser.
// Define USART_PARITY_EN for 8E1 frames with an even-parity bit before stop.
module usart_tx_buf #(
    parameter int  BPS         = 9600,
    parameter int  SYS_CLK_FRE = 50_000_000,
    parameter int  FIFO_DEPTH  = 16,
    localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          uart_txd,
    output logic          tx_busy,
    output logic [CW-1:0] fifo_count
);

    import usart_pkg::*;

    localparam int   BAUD_DIV  = baud_div(SYS_CLK_FRE, BPS);
    localparam int   CNT_W     = $clog2(BAUD_DIV + 1);
    localparam int   IDX_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    state_t                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   txd_q;
    logic                   busy_q;
    logic                   txd_d;
    logic                   bit_last_d;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
`ifdef USART_PARITY_EN
    logic                   par_q;
`endif

    usart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_ready   = !fifo_full;
    assign uart_txd   = txd_q;
    assign tx_busy    = busy_q;
    assign fifo_push  = tx_valid && !fifo_full;
    assign bit_last_d = (bit_cnt_q == BAUD_LAST);

    // Head is taken when idle, or on the final stop cycle for gapless frames.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == IDLE) ||
                       ((state_q == STOP) && bit_last_d));

    // Line level for the current state; registered below so the pin is clean.
    always_comb begin
        txd_d = STOP_BIT;
        case (state_q)
            START:   txd_d = START_BIT;
            DATA:    txd_d = shift_q[0];
`ifdef USART_PARITY_EN
            PARITY:  txd_d = par_q;
`endif
            default: txd_d = STOP_BIT;
        endcase
    end

    // Frame sequencer: bit timing, data shifting and registered line/busy.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            txd_q     <= STOP_BIT;
            busy_q    <= 1'b0;
`ifdef USART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            txd_q  <= txd_d;
            busy_q <= (state_q != IDLE) || !fifo_empty;
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    idx_q     <= '0;
                    if (!fifo_empty) begin
                        shift_q <= fifo_rdata;
`ifdef USART_PARITY_EN
                        par_q   <= ^fifo_rdata;
`endif
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_last_d) begin
                        bit_cnt_q <= '0;
                        idx_q     <= '0;
                        state_q   <= DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_last_d) begin
                        bit_cnt_q <= '0;
                        shift_q   <= shift_q >> 1;
                        if (idx_q == IDX_LAST) begin
`ifdef USART_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
`ifdef USART_PARITY_EN
                PARITY: begin
                    if (bit_last_d) begin
                        bit_cnt_q <= '0;
                        state_q   <= STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_last_d) begin
                        bit_cnt_q <= '0;
                        idx_q     <= '0;
                        if (!fifo_empty) begin
                            shift_q <= fifo_rdata;
`ifdef USART_PARITY_EN
                            par_q   <= ^fifo_rdata;
`endif
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    bit_cnt_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usart_tx_buf.sv
// Scoreboard bench for usart_tx_buf at BAUD_DIV=10.
// A line decoder pops the expected-byte queue filled by the stimulus side.
module tb_usart_tx_buf;

    localparam int CLK_FRE = 50_000_000;
    localparam int BPS     = 5_000_000;
    localparam int DEPTH   = 16;
    localparam int BD      = 10;
`ifdef USART_PARITY_EN
    localparam int FBITS   = 11;
`else
    localparam int FBITS   = 10;
`endif
    localparam int FLEN    = FBITS * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [4:0] fifo_count;

    usart_tx_buf #(
        .BPS         (BPS),
        .SYS_CLK_FRE (CLK_FRE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         starts_q[$];
    bit         mon_en = 1'b0;
    bit         mon_skip = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Expected line level t cycles after the start bit begins.
    function automatic int frame_bit(input logic [7:0] b, input int t);
        int i;
        i = t / BD;
        if (i == 0) return 0;
        if (i <= 8) return int'(b[i-1]);
`ifdef USART_PARITY_EN
        if (i == 9) return int'(^b);
`endif
        return 1;
    endfunction

    // Monitor: decode frames at mid-bit and compare against the queue.
    initial begin
        logic [7:0] b;
        logic       p;
        logic       s;
        b = '0;
        p = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && uart_txd === 1'b0) begin
                starts_q.push_back(cyc);
                repeat (4) @(negedge clk);
                chk("start_bit", int'(uart_txd), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = uart_txd;
                end
`ifdef USART_PARITY_EN
                repeat (BD) @(negedge clk);
                p = uart_txd;
`endif
                repeat (BD) @(negedge clk);
                s = uart_txd;
                if (mon_skip) begin
                    mon_skip = 1'b0;
                end else begin
                    chk("stop_bit", int'(s), 1);
`ifdef USART_PARITY_EN
                    chk("parity_bit", int'(p), int'(^b));
`endif
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got byte %02h, expected none",
                                 b);
                    end else begin
                        chk("frame_data", int'(b), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Offer a byte from a negedge; acc is the accepting posedge.
    task automatic send(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tx_ready stayed 0, required 1");
            tx_valid = 1'b0;
            acc = -1;
        end else begin
            exp_q.push_back(b);
            acc = cyc + 1;
        end
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        tx_valid = 1'b0;
        while ((exp_q.size() != 0 || tx_busy) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 6000 ? 1 : 0, 1);
        repeat (5) @(negedge clk);
    endtask

    // Exact waveform of one frame accepted at edge k into an idle DUT.
    task automatic check_wave(input logic [7:0] b, input int k);
        wait_cyc(k + 1);
        chk("latency_not_early", int'(uart_txd), 1);
        for (int t = 0; t < FLEN; t++) begin
            wait_cyc(k + 2 + t);
            chk($sformatf("wave_%02h_t%0d", b, t), int'(uart_txd),
                frame_bit(b, t));
        end
        wait_cyc(k + 1 + FLEN);
        chk("busy_last_stop", int'(tx_busy), 1);
        wait_cyc(k + 2 + FLEN);
        chk("busy_after_frame", int'(tx_busy), 0);
        chk("idle_line", int'(uart_txd), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        int k;
        int a;
        int lows;
        repeat (3) @(negedge clk);
        chk("rst_txd", int'(uart_txd), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte timing.
        send(8'h55, k);
        tx_valid = 1'b0;
        check_wave(8'h55, k);
        drain();

        // Parity-relevant bytes.
        send(8'h07, k);
        tx_valid = 1'b0;
        check_wave(8'h07, k);
        drain();
        send(8'h03, k);
        tx_valid = 1'b0;
        check_wave(8'h03, k);
        drain();

        // Three back-to-back frames.
        starts_q.delete();
        send(8'hA1, k);
        send(8'h02, a);
        send(8'hFF, a);
        tx_valid = 1'b0;
        chk("b2b_count_after_push", int'(fifo_count), 2);
        wait_cyc(k + FLEN);
        chk("b2b_count_pre_pop", int'(fifo_count), 2);
        wait_cyc(k + FLEN + 1);
        chk("b2b_count_pop1", int'(fifo_count), 1);
        wait_cyc(k + 2 * FLEN + 1);
        chk("b2b_count_pop2", int'(fifo_count), 0);
        drain();
        chk("b2b_frames", starts_q.size(), 3);
        if (starts_q.size() == 3) begin
            chk("b2b_first_start", starts_q[0], k + 2);
            chk("b2b_gap1", starts_q[1] - starts_q[0], FLEN);
            chk("b2b_gap2", starts_q[2] - starts_q[1], FLEN);
        end

        // Fill the FIFO with valid held high; the 18th byte must wait.
        send(8'($urandom), k);
        for (int i = 1; i < 17; i++) send(8'($urandom), a);
        chk("full_count", int'(fifo_count), 16);
        chk("full_ready", int'(tx_ready), 0);
        send(8'($urandom), a);
        tx_valid = 1'b0;
        chk("held_byte_accept_edge", a, k + FLEN + 2);
        drain();

        // Push and pop on the same edge at count 5.
        send(8'($urandom), k);
        for (int i = 0; i < 5; i++) send(8'($urandom), a);
        tx_valid = 1'b0;
        wait_cyc(k + FLEN);
        chk("pp_count_before", int'(fifo_count), 5);
        send(8'($urandom), a);
        tx_valid = 1'b0;
        chk("pp_accept_edge", a, k + FLEN + 1);
        chk("pp_count_after", int'(fifo_count), 5);
        drain();

        // Reset during data bit 3 with 4 bytes queued.
        send(8'h3C, k);
        for (int i = 0; i < 4; i++) send(8'($urandom), a);
        tx_valid = 1'b0;
        wait_cyc(k + 2 + 4 * BD + 2);
        chk("rst_mid_queued", int'(fifo_count), 4);
        rst = 1'b1;
        mon_skip = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_txd", int'(uart_txd), 1);
        chk("rst_mid_count", int'(fifo_count), 0);
        chk("rst_mid_ready", int'(tx_ready), 1);
        lows = 0;
        for (int i = 0; i < 3 * FLEN; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
        chk("rst_no_more_frames", lows, 0);
        chk("rst_idle_busy", int'(tx_busy), 0);

        // Random traffic with random gaps.
        for (int i = 0; i < 40; i++) begin
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 40)) @(negedge clk);
            send(8'($urandom), a);
        end
        tx_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
